// File: rtl/fixed_point_alu_seq.sv
// Sequential signed fixed-point ALU (Qm.n, N total bits, Q fractional bits).
// add/sub finish in one cycle; multiply is shift-add and divide is restoring
// division, both one bit per cycle, behind a start/busy/done handshake.
// Optional feature macro: FXP_ALU_SAT_EN -- when defined, overflowing results
// saturate to the most positive/negative value; otherwise they wrap.
module fixed_point_alu_seq #(
    parameter int N = 32,
    parameter int Q = 20
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [1:0]   op,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] result,
    output logic         overflow
);
    localparam int W  = 2 * N;      // full product width
    localparam int DW = N + Q;      // dividend (|a| << Q) and quotient width
    localparam int CW = $clog2(DW + 1);

    typedef enum logic [1:0] {IDLE, MUL, DIV, FIN} state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           sign_q, sign_d;
    logic [W-1:0]   acc_q, acc_d;
    logic [W-1:0]   mcand_q, mcand_d;
    logic [N-1:0]   mplier_q, mplier_d;
    logic [DW-1:0]  divq_q, divq_d;
    logic [N-1:0]   rem_q, rem_d;
    logic [N-1:0]   divisor_q, divisor_d;
    logic [N-1:0]   result_q, result_d;
    logic           overflow_q, overflow_d;

    logic signed [N:0] sa, sb, sum;
    logic [W-1:0]      acc_nx;
    logic [N:0]        rem_sh;
    logic              qbit;
    logic [DW-1:0]     divq_nx;

    // Unsigned magnitude; -2^(N-1) maps to 2^(N-1), which still fits in N bits.
    function automatic logic [N-1:0] magnitude(input logic [N-1:0] x);
        return x[N-1] ? -x : x;
    endfunction

    function automatic logic [N-1:0] clamp(input logic neg);
        return neg ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};
    endfunction

    // Apply the sign to a magnitude, flag overflow, and wrap or saturate.
    // A zero magnitude is always returned as +0.
    function automatic logic [N:0] finalize(input logic [W-1:0] mag, input logic sign);
        logic         neg;
        logic         ovf;
        logic [N-1:0] lo;
        logic [N-1:0] val;
        logic [W-1:0] lim;
        lim = W'(1) << (N - 1);
        lo  = mag[N-1:0];
        neg = sign && (mag != '0);
        ovf = neg ? (mag > lim) : (mag >= lim);
        val = neg ? -lo : lo;
`ifdef FXP_ALU_SAT_EN
        if (ovf) val = clamp(neg);
`endif
        return {ovf, val};
    endfunction

    // Add/sub overflow: the N+1-bit sum's top two bits disagree.
    function automatic logic [N:0] addsub_finalize(input logic signed [N:0] s);
        logic         ovf;
        logic [N-1:0] val;
        ovf = s[N] ^ s[N-1];
        val = s[N-1:0];
`ifdef FXP_ALU_SAT_EN
        if (ovf) val = clamp(s[N]);
`endif
        return {ovf, val};
    endfunction

    // Next-state, iteration datapath and result loading on entry to FIN.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        sign_d     = sign_q;
        acc_d      = acc_q;
        mcand_d    = mcand_q;
        mplier_d   = mplier_q;
        divq_d     = divq_q;
        rem_d      = rem_q;
        divisor_d  = divisor_q;
        result_d   = result_q;
        overflow_d = overflow_q;

        sa      = $signed({a[N-1], a});
        sb      = $signed({b[N-1], b});
        sum     = '0;
        acc_nx  = acc_q + (mplier_q[0] ? mcand_q : '0);
        rem_sh  = {rem_q, divq_q[DW-1]};
        qbit    = (rem_sh >= {1'b0, divisor_q});
        divq_nx = {divq_q[DW-2:0], qbit};

        case (state_q)
            IDLE: begin
                if (start) begin
                    sign_d = a[N-1] ^ b[N-1];
                    cnt_d  = '0;
                    case (op)
                        2'b10: begin
                            acc_d    = '0;
                            mcand_d  = W'(magnitude(a));
                            mplier_d = magnitude(b);
                            state_d  = MUL;
                        end
                        2'b11: begin
                            if (b == '0) begin
                                // Divide by zero: no iterations, clamp by sign of a.
                                result_d   = clamp(a[N-1]);
                                overflow_d = 1'b1;
                                state_d    = FIN;
                            end else begin
                                divq_d    = {magnitude(a), {Q{1'b0}}};
                                rem_d     = '0;
                                divisor_d = magnitude(b);
                                state_d   = DIV;
                            end
                        end
                        default: begin
                            sum = op[0] ? (sa - sb) : (sa + sb);
                            {overflow_d, result_d} = addsub_finalize(sum);
                            state_d = FIN;
                        end
                    endcase
                end
            end
            MUL: begin
                acc_d    = acc_nx;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + CW'(1);
                if (cnt_q == CW'(N - 1)) begin
                    {overflow_d, result_d} = finalize(acc_nx >> Q, sign_q);
                    state_d = FIN;
                end
            end
            DIV: begin
                // Remainder stays below the divisor, so its top bit is always clear.
                rem_d  = qbit ? N'(rem_sh - {1'b0, divisor_q}) : rem_sh[N-1:0];
                divq_d = divq_nx;
                cnt_d  = cnt_q + CW'(1);
                if (cnt_q == CW'(DW - 1)) begin
                    {overflow_d, result_d} = finalize(W'(divq_nx), sign_q);
                    state_d = FIN;
                end
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any operation in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            sign_q     <= 1'b0;
            acc_q      <= '0;
            mcand_q    <= '0;
            mplier_q   <= '0;
            divq_q     <= '0;
            rem_q      <= '0;
            divisor_q  <= '0;
            result_q   <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            sign_q     <= sign_d;
            acc_q      <= acc_d;
            mcand_q    <= mcand_d;
            mplier_q   <= mplier_d;
            divq_q     <= divq_d;
            rem_q      <= rem_d;
            divisor_q  <= divisor_d;
            result_q   <= result_d;
            overflow_q <= overflow_d;
        end
    end

    assign busy     = (state_q != IDLE);
    assign done     = (state_q == FIN);
    assign result   = result_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_fixed_point_alu_seq.sv
// Self-checking bench for fixed_point_alu_seq (N=32, Q=20).
module tb_fixed_point_alu_seq;
    localparam int N = 32;
    localparam int Q = 20;
`ifdef FXP_ALU_SAT_EN
    localparam logic [31:0] OVF_ADD_RES = 32'h7FFFFFFF;
`else
    localparam logic [31:0] OVF_ADD_RES = 32'h80000000;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [1:0]    op = 2'b00;
    logic [N-1:0]  a = '0;
    logic [N-1:0]  b = '0;
    logic          busy;
    logic          done;
    logic [N-1:0]  result;
    logic          overflow;

    fixed_point_alu_seq #(.N(N), .Q(Q)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
        .busy(busy), .done(done), .result(result), .overflow(overflow)
    );

    initial forever #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;
    int last_done = -1;

    typedef struct {
        int          s;
        int          d;
        logic [31:0] r;
        logic        o;
    } exp_t;
    exp_t q[$];

    logic [31:0] exp_res = '0;
    logic        exp_ovf = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d actual=%0h expected=%0h", name, cyc, act, exp);
        end
    endtask

    // Reference: exact signed arithmetic on 64-bit integers.
    function automatic void model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                                  output logic [31:0] r, output logic ov);
        longint sx, sy, mx, my, mag, ex;
        bit neg;
        sx  = longint'($signed(x));
        sy  = longint'($signed(y));
        mx  = (sx < 0) ? -sx : sx;
        my  = (sy < 0) ? -sy : sy;
        neg = (sx < 0) != (sy < 0);
        ex  = 0;
        case (o)
            2'd0: ex = sx + sy;
            2'd1: ex = sx - sy;
            2'd2: begin
                mag = (mx * my) >> Q;
                ex  = neg ? -mag : mag;
            end
            default: begin
                if (sy == 0) begin
                    r  = (sx < 0) ? 32'h80000000 : 32'h7FFFFFFF;
                    ov = 1'b1;
                    return;
                end
                mag = (mx << Q) / my;
                ex  = neg ? -mag : mag;
            end
        endcase
        ov = (ex > 64'sd2147483647) || (ex < -64'sd2147483648);
        r  = ex[31:0];
`ifdef FXP_ALU_SAT_EN
        if (ov) r = (ex < 0) ? 32'h80000000 : 32'h7FFFFFFF;
`endif
    endfunction

    function automatic int latency(input logic [1:0] o, input logic [31:0] y);
        if (o < 2) return 1;
        if (o == 2) return N + 1;
        return (y == 0) ? 1 : N + Q + 1;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called just after a rising edge; holds start for one sampling edge.
    task automatic issue(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        logic [31:0] r;
        logic        ov;
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        if (cyc > last_done) begin
            model(o, x, y, r, ov);
            q.push_back('{s: cyc, d: cyc + latency(o, y), r: r, o: ov});
            last_done = cyc + latency(o, y);
        end
        tick();
        start = 1'b0;
        op    = 2'($urandom_range(0, 3));
        a     = $urandom;
        b     = $urandom;
    endtask

    task automatic wait_done();
        while (cyc < last_done) tick();
    endtask

    task automatic directed(input string name, input logic [1:0] o, input logic [31:0] x,
                            input logic [31:0] y, input logic [31:0] er, input logic eo);
        issue(o, x, y);
        wait_done();
        chk({name, "_done"}, done, 1);
        chk({name, "_result"}, result, er);
        chk({name, "_ovf"}, overflow, eo);
        tick();
    endtask

    function automatic logic [31:0] rnd_operand();
        logic [31:0] v;
        case ($urandom_range(0, 5))
            0: v = $urandom;
            1: v = 32'h0;
            2: v = 32'h80000000;
            3: v = 32'h7FFFFFFF;
            4: v = 32'($urandom_range(0, 32'h003FFFFF));
            default: v = 32'($urandom_range(0, 32'h07FFFFFF));
        endcase
        if ($urandom_range(0, 1) == 1) v = -v;
        return v;
    endfunction

    // Cycle-by-cycle comparison of all outputs against the expected schedule.
    initial begin
        bit exp_busy;
        bit exp_done;
        forever begin
            @(negedge clk);
            exp_busy = (q.size() > 0) && (cyc > q[0].s);
            exp_done = (q.size() > 0) && (cyc == q[0].d);
            if (exp_done) begin
                exp_res = q[0].r;
                exp_ovf = q[0].o;
            end
            chk("cyc_busy", busy, exp_busy);
            chk("cyc_done", done, exp_done);
            chk("cyc_result", result, exp_res);
            chk("cyc_ovf", overflow, exp_ovf);
            if (exp_done) void'(q.pop_front());
        end
    end

    initial begin
        logic [31:0] r;
        logic        ov;
        int          k;

        // Hand-computed values that pin the reference model.
        model(2'd0, 32'h00180000, 32'h00080000, r, ov); chk("pin_add", {ov, r}, {1'b0, 32'h00200000});
        model(2'd2, 32'hFFFFE000, 32'h00002000, r, ov); chk("pin_mul", {ov, r}, {1'b0, 32'hFFFFFFC0});
        model(2'd3, 32'h00100000, 32'h00400000, r, ov); chk("pin_div", {ov, r}, {1'b0, 32'h00040000});
        model(2'd3, 32'hFFF00000, 32'h00000000, r, ov); chk("pin_div0", {ov, r}, {1'b1, 32'h80000000});
        model(2'd0, 32'h7FF00000, 32'h00100000, r, ov); chk("pin_ovf", {ov, r}, {1'b1, OVF_ADD_RES});

        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_result", result, 0);
        chk("rst_ovf", overflow, 0);
        rst = 1'b0;
        tick();

        directed("add", 2'd0, 32'h00180000, 32'h00080000, 32'h00200000, 1'b0);
        directed("mul", 2'd2, 32'hFFFFE000, 32'h00002000, 32'hFFFFFFC0, 1'b0);
        directed("div", 2'd3, 32'h00100000, 32'h00400000, 32'h00040000, 1'b0);
        directed("div0", 2'd3, 32'hFFF00000, 32'h00000000, 32'h80000000, 1'b1);
        directed("ovf", 2'd0, 32'h7FF00000, 32'h00100000, OVF_ADD_RES, 1'b1);
        directed("minmag", 2'd2, 32'h80000000, 32'hFFF00000, 32'h80000000, 1'b1);

        // Start during busy and start in the done cycle are both ignored.
        k = cyc;
        issue(2'd2, 32'hFFFFE000, 32'h00002000);
        while (cyc < k + 4) tick();
        issue(2'd0, 32'h00100000, 32'h00100000);
        wait_done();
        chk("hs_result", result, 32'hFFFFFFC0);
        issue(2'd0, 32'h00100000, 32'h00100000);
        repeat (3) tick();

        // Reset in the middle of a divide.
        k = cyc;
        issue(2'd3, 32'h00100000, 32'h00400000);
        while (cyc < k + 10) tick();
        rst = 1'b1;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_result", result, 0);
        q.delete();
        last_done = cyc;
        exp_res = '0;
        exp_ovf = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        directed("post_rst_add", 2'd0, 32'h00180000, 32'h00080000, 32'h00200000, 1'b0);

        // Randomized traffic with occasional stray starts.
        for (int i = 0; i < 150; i++) begin
            issue(2'($urandom_range(0, 3)), rnd_operand(), rnd_operand());
            if ($urandom_range(0, 2) == 0) begin
                repeat ($urandom_range(0, 3)) tick();
                issue(2'($urandom_range(0, 3)), rnd_operand(), rnd_operand());
            end
            while (cyc <= last_done) tick();
            repeat ($urandom_range(0, 2)) tick();
        end

        wait_done();
        repeat (3) tick();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
